noc_block_doppler_tracker: RTL and testbench
============================================

NOC_BLOCK_DOPPLER_TRACKER -- requirements
Module: noc_block_doppler_tracker

Interface
REQ-001 SHALL have parameter NOC_ID, default 64'hD0991E7_0000_0000, block identifier returned on readback address 0.
REQ-002 SHALL have parameter MAX_SUM_LEN, default 16, history depth of the I/Q moving average.
REQ-003 SHALL have parameter MAX_ZC_LEN, default 16, history depth of the zero-crossing interval sum.
REQ-004 SHALL have parameters SR_SUM_LEN=192, SR_DIVISOR=193, SR_ZC_SUM_LEN=194, SR_THRESHOLD=195, SR_OFFSET=196, the setting-register addresses.
REQ-005 SHALL use one clock with an asynchronous, active-low reset.
REQ-006 ce_clk  in  1  sole clock; all logic on rising edge.
REQ-007 ce_rst_n  in  1  asynchronous active-low reset.
REQ-008 set_stb / set_addr / set_data  in  1/8/32  settings write strobe, address, data.
REQ-009 rb_addr  in  1  readback select; rb_data  out  64  addr 0 = NOC_ID, addr 1 = sign-extended doppler_est.
REQ-010 s_axis_tdata/tlast/tvalid  in  32/1/1; s_axis_tready  out  1  input sample stream, sc16 (I=[31:16], Q=[15:0]).
REQ-011 m_axis_tdata/tlast/tvalid  out  32/1/1; m_axis_tready  in  1  averaged sc16 output stream.
REQ-012 doppler_est  out  32  signed doppler estimate; doppler_valid  out  1  one-cycle update strobe.

Function
REQ-013 SHALL latch set_data on set_stb into the register matching set_addr; other addresses ignored. SUM_LEN, DIVISOR, ZC_SUM_LEN are clamped to 1..MAX. THRESHOLD is 16-bit unsigned. OFFSET is 32-bit signed.
REQ-014 Pipeline advance: en = m_axis_tready | ~m_axis_tvalid. s_axis_tready SHALL equal en. A beat transfers when s_axis_tvalid & en.
REQ-015 Latency SHALL be exactly 2 cycles from input transfer to m_axis_tvalid when unstalled. Stalls SHALL lose no data. tlast SHALL travel aligned with its sample.
REQ-016 Moving sum, separately for I and Q, 20-bit signed: sum += x[n] - x[n-SUM_LEN]. Samples before history fill count as 0.
REQ-017 A write to SR_SUM_LEN SHALL clear the history and both sums.
REQ-018 Output SHALL equal floor(sum/DIVISOR + 0.5), via a constant reciprocal table (DIVISOR 1..16, 17 fractional bits), saturated to int16. DIVISOR=1 SHALL be an exact pass-through.
REQ-019 Zero crossing: on each output beat, rising crossing = prev I < 0 and cur I >= 0 and (cur I - prev I) > THRESHOLD.
REQ-020 Interval counter: 16-bit, counts output beats since the last crossing, saturates at 65535, reloads to 1 on a crossing.
REQ-021 On every crossing after the first, the interval SHALL be pushed into a ZC_SUM_LEN-deep moving sum. Same cycle: doppler_est = zc_sum - OFFSET and doppler_valid pulses for 1 cycle.
REQ-022 A write to SR_ZC_SUM_LEN SHALL clear the ZC history, zc_sum and the first-crossing flag.
REQ-023 A settings write coinciding with a data beat SHALL take effect on the next beat; the current beat uses the old value.

Reset
REQ-024 On ce_rst_n low, immediately: m_axis_tvalid=0, m_axis_tdata=0, tlast=0, doppler_est=0, doppler_valid=0, all histories/sums/counters=0.
REQ-025 Register reset values: SUM_LEN=1, DIVISOR=1, ZC_SUM_LEN=1, THRESHOLD=0, OFFSET=0.
REQ-026 Reset mid-packet SHALL discard all in-flight beats; no partial output after release.

Configuration
REQ-027 Macro DOPPLER_TRACKER_ZC_EN: defined -> zero-crossing tracker (REQ-019..022) built.
REQ-028 Macro DOPPLER_TRACKER_ZC_EN: undefined -> no tracker logic; doppler_est=0, doppler_valid=0; SR_ZC_SUM_LEN, SR_THRESHOLD and SR_OFFSET ignored; the averaging path is unchanged.

Verification
REQ-029 Reset release -> m_axis_tvalid=0; rb_addr=0 reads NOC_ID.
REQ-030 SUM_LEN=1, DIVISOR=1, ramp I=k, Q=-k, k=0..31 -> identical output; first output 2 cycles after first input; tlast on the 32nd beat.
REQ-031 SUM_LEN=4, DIVISOR=4, same ramp -> k=3: I=2 (6/4), Q=-1 (-6/4); k=10: I=9 (34/4), Q=-8 (-34/4).
REQ-032 ZC_EN defined, SUM_LEN=1, ZC_SUM_LEN=1, THRESHOLD=0, OFFSET=0, I=round(4096*sin(2*pi*n/10)), 64 beats -> doppler_valid pulses with doppler_est=10 from the second rising crossing on; OFFSET=3 -> 7.
REQ-033 m_axis_tready held low 5 cycles mid-packet -> s_axis_tready low; after release all 32 beats appear in order, none lost or repeated.
REQ-034 Build without DOPPLER_TRACKER_ZC_EN, stimulus of REQ-032 -> doppler_valid never asserts; averaged output matches REQ-030.

Source files
------------

// File: rtl/noc_block_doppler_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : noc_block_doppler_tracker_if
//  Description : AXI-Stream style sample bus (sc16 data, last, valid/ready).
//  Revision    : 1.0 - initial release
// ============================================================================
interface noc_block_doppler_tracker_if;
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/noc_block_doppler_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : noc_block_doppler_tracker
//  Description : I/Q moving-average decimating-free filter with a rounded
//                reciprocal divider; optional zero-crossing doppler tracker
//                built when DOPPLER_TRACKER_ZC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_block_doppler_tracker #(
    parameter logic [63:0] NOC_ID        = 64'hD0991E7_0000_0000,
    parameter int          MAX_SUM_LEN   = 16,
    parameter int          MAX_ZC_LEN    = 16,
    parameter int unsigned SR_SUM_LEN    = 192,
    parameter int unsigned SR_DIVISOR    = 193,
    parameter int unsigned SR_ZC_SUM_LEN = 194,
    parameter int unsigned SR_THRESHOLD  = 195,
    parameter int unsigned SR_OFFSET     = 196
) (
    input  wire                 ce_clk,
    input  wire                 ce_rst_n,
    input  wire                 set_stb,
    input  wire  [7:0]          set_addr,
    input  wire  [31:0]         set_data,
    input  wire                 rb_addr,
    output logic [63:0]         rb_data,
    noc_block_doppler_tracker_if.slave  s_axis,
    noc_block_doppler_tracker_if.master m_axis,
    output logic [31:0]         doppler_est,
    output logic                doppler_valid
);
    localparam int SL_IW = (MAX_SUM_LEN > 1) ? $clog2(MAX_SUM_LEN) : 1;
    localparam int ZL_IW = (MAX_ZC_LEN > 1) ? $clog2(MAX_ZC_LEN) : 1;

    // Lengths are held as (value - 1) so they index the history directly.
    function automatic logic [31:0] clamp_m1(input logic [31:0] d, input int unsigned max);
        if (d == 32'd0)     return 32'd0;
        else if (d >= max)  return max - 32'd1;
        else                return d - 32'd1;
    endfunction

    // round(2^17 / divisor), indexed by divisor - 1
    function automatic logic [17:0] recip(input logic [3:0] dm1);
        case (dm1)
            4'd0:  return 18'd131072;  4'd1:  return 18'd65536;
            4'd2:  return 18'd43691;   4'd3:  return 18'd32768;
            4'd4:  return 18'd26214;   4'd5:  return 18'd21845;
            4'd6:  return 18'd18725;   4'd7:  return 18'd16384;
            4'd8:  return 18'd14564;   4'd9:  return 18'd13107;
            4'd10: return 18'd11916;   4'd11: return 18'd10923;
            4'd12: return 18'd10082;   4'd13: return 18'd9362;
            4'd14: return 18'd8738;    4'd15: return 18'd8192;
        endcase
    endfunction

    function automatic logic [15:0] scale(input logic signed [19:0] s, input logic [17:0] r);
        logic signed [39:0] p;
        p = (40'(s) * $signed({22'd0, r}) + 40'sd65536) >>> 17;
        if (p > 40'sd32767)       return 16'h7fff;
        else if (p < -40'sd32768) return 16'h8000;
        else                      return p[15:0];
    endfunction

    logic [SL_IW-1:0]   r_sum_len_m1;
    logic [3:0]         r_div_m1;
    logic signed [15:0] r_hist_i [MAX_SUM_LEN];
    logic signed [15:0] r_hist_q [MAX_SUM_LEN];
    logic signed [19:0] r_sum_i, r_sum_q;
    logic               r_s1_valid, r_s1_last;
    logic signed [19:0] r_s1_i, r_s1_q;
    logic [3:0]         r_s1_div;
    logic               r_m_valid, r_m_last;
    logic [31:0]        r_m_data;

    logic               w_en, w_xfer, w_sl_wr;
    logic signed [15:0] w_x_i, w_x_q, w_out_i, w_out_q;
    logic signed [19:0] w_sum_i_nxt, w_sum_q_nxt;

    assign w_en    = m_axis.tready | ~r_m_valid;
    assign w_xfer  = s_axis.tvalid & w_en;
    assign w_sl_wr = set_stb && (set_addr == SR_SUM_LEN[7:0]);
    assign w_x_i   = s_axis.tdata[31:16];
    assign w_x_q   = s_axis.tdata[15:0];

    assign w_sum_i_nxt = r_sum_i + 20'(w_x_i) - 20'(r_hist_i[r_sum_len_m1]);
    assign w_sum_q_nxt = r_sum_q + 20'(w_x_q) - 20'(r_hist_q[r_sum_len_m1]);
    assign w_out_i     = scale(r_s1_i, recip(r_s1_div));
    assign w_out_q     = scale(r_s1_q, recip(r_s1_div));

    assign s_axis.tready = w_en;
    assign m_axis.tvalid = r_m_valid;
    assign m_axis.tdata  = r_m_data;
    assign m_axis.tlast  = r_m_last;
    assign rb_data       = rb_addr ? {{32{doppler_est[31]}}, doppler_est} : NOC_ID;

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            r_sum_len_m1 <= '0;
            r_div_m1     <= '0;
        end else if (set_stb) begin
            if (set_addr == SR_SUM_LEN[7:0]) r_sum_len_m1 <= SL_IW'(clamp_m1(set_data, MAX_SUM_LEN));
            if (set_addr == SR_DIVISOR[7:0]) r_div_m1     <= 4'(clamp_m1(set_data, 16));
        end
    end

    // A length change restarts the window; the beat in flight still uses the old sums.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n || w_sl_wr) begin
            r_sum_i <= '0;
            r_sum_q <= '0;
            for (int k = 0; k < MAX_SUM_LEN; k++) begin
                r_hist_i[k] <= '0;
                r_hist_q[k] <= '0;
            end
        end else if (w_xfer) begin
            r_sum_i     <= w_sum_i_nxt;
            r_sum_q     <= w_sum_q_nxt;
            r_hist_i[0] <= w_x_i;
            r_hist_q[0] <= w_x_q;
            for (int k = 1; k < MAX_SUM_LEN; k++) begin
                r_hist_i[k] <= r_hist_i[k-1];
                r_hist_q[k] <= r_hist_q[k-1];
            end
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_i     <= '0;
            r_s1_q     <= '0;
            r_s1_div   <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_m_data   <= '0;
        end else if (w_en) begin
            r_s1_valid <= s_axis.tvalid;
            r_s1_last  <= s_axis.tlast;
            r_s1_i     <= w_sum_i_nxt;
            r_s1_q     <= w_sum_q_nxt;
            r_s1_div   <= r_div_m1;
            r_m_valid  <= r_s1_valid;
            r_m_last   <= r_s1_last;
            r_m_data   <= {w_out_i, w_out_q};
        end
    end

`ifdef DOPPLER_TRACKER_ZC_EN
    logic [ZL_IW-1:0]   r_zc_len_m1;
    logic [15:0]        r_thresh;
    logic [31:0]        r_offset;
    logic [15:0]        r_zc_hist [MAX_ZC_LEN];
    logic [19:0]        r_zc_sum;
    logic [15:0]        r_cnt;
    logic signed [15:0] r_prev_i;
    logic               r_seen;
    logic [31:0]        r_dop_est;
    logic               r_dop_valid;

    logic               w_fire, w_cross, w_zc_wr;
    logic signed [16:0] w_diff;
    logic [19:0]        w_zc_nxt;

    assign w_fire   = w_en & r_s1_valid;
    assign w_zc_wr  = set_stb && (set_addr == SR_ZC_SUM_LEN[7:0]);
    assign w_diff   = 17'(w_out_i) - 17'(r_prev_i);
    assign w_cross  = r_prev_i[15] & ~w_out_i[15] & (w_diff > $signed({1'b0, r_thresh}));
    assign w_zc_nxt = r_zc_sum + 20'(r_cnt) - 20'(r_zc_hist[r_zc_len_m1]);

    assign doppler_est   = r_dop_est;
    assign doppler_valid = r_dop_valid;

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            r_zc_len_m1 <= '0;
            r_thresh    <= '0;
            r_offset    <= '0;
        end else if (set_stb) begin
            if (w_zc_wr)                       r_zc_len_m1 <= ZL_IW'(clamp_m1(set_data, MAX_ZC_LEN));
            if (set_addr == SR_THRESHOLD[7:0]) r_thresh    <= set_data[15:0];
            if (set_addr == SR_OFFSET[7:0])    r_offset    <= set_data;
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            r_zc_sum    <= '0;
            r_cnt       <= '0;
            r_prev_i    <= '0;
            r_seen      <= 1'b0;
            r_dop_est   <= '0;
            r_dop_valid <= 1'b0;
            for (int k = 0; k < MAX_ZC_LEN; k++) r_zc_hist[k] <= '0;
        end else begin
            r_dop_valid <= 1'b0;
            if (w_fire) begin
                r_prev_i <= w_out_i;
                if (w_cross)          r_cnt <= 16'd1;
                else if (r_cnt != '1) r_cnt <= r_cnt + 16'd1;
            end
            // The first crossing only opens an interval; later ones close one.
            if (w_zc_wr) begin
                r_zc_sum <= '0;
                r_seen   <= 1'b0;
                for (int k = 0; k < MAX_ZC_LEN; k++) r_zc_hist[k] <= '0;
            end else if (w_fire && w_cross) begin
                r_seen <= 1'b1;
                if (r_seen) begin
                    r_zc_sum     <= w_zc_nxt;
                    r_zc_hist[0] <= r_cnt;
                    for (int k = 1; k < MAX_ZC_LEN; k++) r_zc_hist[k] <= r_zc_hist[k-1];
                    r_dop_est    <= 32'(w_zc_nxt) - r_offset;
                    r_dop_valid  <= 1'b1;
                end
            end
        end
    end
`else
    assign doppler_est   = '0;
    assign doppler_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_block_doppler_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_block_doppler_tracker
//  Description : Directed self-checking bench for noc_block_doppler_tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_block_doppler_tracker;
    localparam logic [63:0] C_NOC_ID = 64'hD0991E7_0000_0000;
    localparam int C_SR_SUM_LEN  = 192;
    localparam int C_SR_DIVISOR  = 193;
    localparam int C_SR_ZC_LEN   = 194;
    localparam int C_SR_THRESH   = 195;
    localparam int C_SR_OFFSET   = 196;

    logic        ce_clk   = 1'b0;
    logic        ce_rst_n = 1'b0;
    logic        set_stb  = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic        rb_addr  = 1'b0;
    logic [63:0] rb_data;
    logic [31:0] doppler_est;
    logic        doppler_valid;

    noc_block_doppler_tracker_if s_if ();
    noc_block_doppler_tracker_if m_if ();

    noc_block_doppler_tracker u_dut (
        .ce_clk        (ce_clk),
        .ce_rst_n      (ce_rst_n),
        .set_stb       (set_stb),
        .set_addr      (set_addr),
        .set_data      (set_data),
        .rb_addr       (rb_addr),
        .rb_data       (rb_data),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .doppler_est   (doppler_est),
        .doppler_valid (doppler_valid)
    );

    always #5 ce_clk = ~ce_clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          t_in  = 0;
    logic [32:0] out_q [$];
    int          out_cyc [$];
    logic [31:0] dop_q [$];
    logic [31:0] stim [$];
    int          sine_tab [10] = '{0, 2408, 3896, 3896, 2408, 0, -2408, -3896, -3896, -2408};

    always @(posedge ce_clk) cyc <= cyc + 1;

    always @(negedge ce_clk) begin
        if (m_if.tvalid && m_if.tready) begin
            out_q.push_back({m_if.tlast, m_if.tdata});
            out_cyc.push_back(cyc);
        end
        if (doppler_valid) dop_q.push_back(doppler_est);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input int data);
        set_stb  = 1'b1;
        set_addr = addr[7:0];
        set_data = data;
        @(negedge ce_clk);
        set_stb  = 1'b0;
    endtask

    task automatic clear_logs();
        out_q.delete();
        out_cyc.delete();
        dop_q.delete();
        stim.delete();
    endtask

    task automatic send_stream();
        for (int k = 0; k < stim.size(); k++) begin
            int guard;
            guard       = 0;
            s_if.tdata  = stim[k];
            s_if.tlast  = (k == stim.size() - 1);
            s_if.tvalid = 1'b1;
            #1;
            while (!s_if.tready && guard < 100) begin
                @(negedge ce_clk);
                #1;
                guard++;
            end
            if (guard >= 100) check("tready_timeout", guard, 0);
            if (k == 0) t_in = cyc;
            @(negedge ce_clk);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int guard;
        guard = 0;
        while (out_q.size() < n && guard < 200) begin
            @(negedge ce_clk);
            guard++;
        end
        repeat (3) @(negedge ce_clk);
        check("out_count", out_q.size(), n);
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Window sum computed directly over the stimulus, rounded in real arithmetic.
    task automatic check_avg(input string tag, input int len, input int div);
        for (int k = 0; k < stim.size(); k++) begin
            int si, sq, ei, eq;
            logic signed [15:0] a, b;
            logic [15:0] ei16, eq16;
            si = 0;
            sq = 0;
            for (int j = k - len + 1; j <= k; j++) begin
                if (j >= 0) begin
                    a  = stim[j][31:16];
                    b  = stim[j][15:0];
                    si += a;
                    sq += b;
                end
            end
            ei   = sat16(int'($floor(real'(si) / real'(div) + 0.5)));
            eq   = sat16(int'($floor(real'(sq) / real'(div) + 0.5)));
            ei16 = ei[15:0];
            eq16 = eq[15:0];
            check($sformatf("%s[%0d]", tag, k), out_q[k], {(k == stim.size() - 1), ei16, eq16});
        end
    endtask

    task automatic load_ramp(input int n);
        for (int k = 0; k < n; k++) stim.push_back({16'(k), 16'(-k)});
    endtask

    task automatic load_const(input int n, input int v);
        for (int k = 0; k < n; k++) stim.push_back({16'(v), 16'(-v)});
    endtask

    task automatic load_sine(input int n);
        for (int k = 0; k < n; k++) begin
            int sv;
            logic [15:0] s16;
            sv  = sine_tab[k % 10];
            s16 = sv[15:0];
            stim.push_back({s16, 16'h0000});
        end
    endtask

    task automatic check_dop(input string tag, input int n, input int v);
        check({tag, "_pulses"}, dop_q.size(), n);
        foreach (dop_q[i]) check($sformatf("%s[%0d]", tag, i), dop_q[i], v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(negedge ce_clk);
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tdata", m_if.tdata, 0);
        check("rst_dvalid", doppler_valid, 0);
        #1 check("rb_noc_id", rb_data, C_NOC_ID);
        @(negedge ce_clk);
        ce_rst_n = 1'b1;
        @(negedge ce_clk);
        check("rel_tvalid", m_if.tvalid, 0);
        rb_addr = 1'b1;
        #1 check("rb_dop_rst", rb_data, 64'd0);
        rb_addr = 1'b0;

        // Pass-through ramp; divisor 0 clamps to 1
        clear_logs();
        wr(C_SR_DIVISOR, 0);
        wr(C_SR_SUM_LEN, 1);
        load_ramp(32);
        send_stream();
        wait_out(32);
        check("latency", out_cyc[0] - t_in, 2);
        check_avg("ramp1", 1, 1);

        // Length-4 average
        clear_logs();
        wr(C_SR_DIVISOR, 4);
        wr(C_SR_SUM_LEN, 4);
        load_ramp(32);
        send_stream();
        wait_out(32);
        check("r4_k3", out_q[3], {1'b0, 16'd2, 16'hFFFF});
        check("r4_k10", out_q[10], {1'b0, 16'd9, 16'hFFF8});
        check_avg("ramp4", 4, 4);

        // Oversized settings clamp to 16
        clear_logs();
        wr(C_SR_DIVISOR, 99);
        wr(C_SR_SUM_LEN, 40);
        load_const(20, 1000);
        send_stream();
        wait_out(20);
        check_avg("clamp", 16, 16);

        // Saturation to int16
        clear_logs();
        wr(C_SR_DIVISOR, 1);
        wr(C_SR_SUM_LEN, 16);
        load_const(20, 30000);
        send_stream();
        wait_out(20);
        check_avg("sat", 16, 1);

        // Downstream stall for 5 cycles mid-packet
        clear_logs();
        wr(C_SR_SUM_LEN, 1);
        load_ramp(32);
        fork
            send_stream();
            begin
                repeat (12) @(posedge ce_clk);
                #1 m_if.tready = 1'b0;
                repeat (2) @(posedge ce_clk);
                #4 check("stall_s_tready", s_if.tready, 0);
                repeat (3) @(posedge ce_clk);
                #1 m_if.tready = 1'b1;
            end
        join
        wait_out(32);
        check_avg("stall", 1, 1);

        // Sine, period 10 beats
        clear_logs();
        wr(C_SR_ZC_LEN, 1);
        wr(C_SR_SUM_LEN, 1);
        load_sine(64);
        send_stream();
        wait_out(64);
        check_avg("sine1", 1, 1);
`ifdef DOPPLER_TRACKER_ZC_EN
        check_dop("zc1", 5, 10);
`else
        check_dop("zc1", 0, 0);
`endif

        clear_logs();
        wr(C_SR_ZC_LEN, 1);
        wr(C_SR_OFFSET, 3);
        load_sine(64);
        send_stream();
        wait_out(64);
        rb_addr = 1'b1;
`ifdef DOPPLER_TRACKER_ZC_EN
        check_dop("zc2", 5, 7);
        #1 check("rb_dop", rb_data, 64'd7);
`else
        check_dop("zc2", 0, 0);
        #1 check("rb_dop", rb_data, 64'd0);
`endif
        rb_addr = 1'b0;

        // Crossing step equal to the threshold does not count
        clear_logs();
        wr(C_SR_ZC_LEN, 1);
        wr(C_SR_THRESH, 2408);
        load_sine(64);
        send_stream();
        wait_out(64);
        check_dop("zc3", 0, 0);

        // Reset with beats in flight
        clear_logs();
        load_ramp(6);
        for (int k = 0; k < 3; k++) begin
            s_if.tdata  = stim[k];
            s_if.tvalid = 1'b1;
            @(negedge ce_clk);
        end
        check("pre_rst_tvalid", m_if.tvalid, 1);
        @(posedge ce_clk);
        #2 ce_rst_n = 1'b0;
        #1 check("midrst_tvalid", m_if.tvalid, 0);
        check("midrst_dop", doppler_est, 0);
        s_if.tvalid = 1'b0;
        out_q.delete();
        repeat (2) @(negedge ce_clk);
        ce_rst_n = 1'b1;
        repeat (6) @(negedge ce_clk);
        check("postrst_outs", out_q.size(), 0);
        check("postrst_tvalid", m_if.tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
